// File: rtl/seq_ctrl_vector_player_if.sv
// rtl/seq_ctrl_vector_player_if.sv - host and controller-side signals of the vector player
// Host loads memories and starts runs; the player drives and samples the sequence controller.
interface seq_ctrl_vector_player_if #(
  parameter int VEC_DEPTH   = 32,
  parameter int CYC_PER_VEC = 8,
  parameter int ERR_W       = 16
);
  localparam int VAW = $clog2(VEC_DEPTH);
  localparam int EAW = $clog2(VEC_DEPTH * CYC_PER_VEC);

  logic             stim_we;
  logic [VAW-1:0]   stim_addr;
  logic [4:0]       stim_data;
  logic             exp_we;
  logic [EAW-1:0]   exp_addr;
  logic [8:0]       exp_data;
  logic [VAW:0]     num_vec;
  logic             start;
  logic             dut_rst;
  logic             dut_zero;
  logic [2:0]       dut_opcode;
  logic [8:0]       dut_outs;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [EAW-1:0]   first_err_idx;
  logic [8:0]       first_err_exp;
  logic [8:0]       first_err_got;

  modport slave (
    input  stim_we, stim_addr, stim_data, exp_we, exp_addr, exp_data, num_vec, start, dut_outs,
    output dut_rst, dut_zero, dut_opcode, busy, done, pass, err_count,
           first_err_idx, first_err_exp, first_err_got
  );

  modport master (
    output stim_we, stim_addr, stim_data, exp_we, exp_addr, exp_data, num_vec, start, dut_outs,
    input  dut_rst, dut_zero, dut_opcode, busy, done, pass, err_count,
           first_err_idx, first_err_exp, first_err_got
  );
endinterface

// File: rtl/seq_ctrl_vector_player.sv
// rtl/seq_ctrl_vector_player.sv - stimulus replay and per-clock output checker for the sequence controller
// Each stored vector is held for one fetch cycle while every clock's outputs are compared to expected data.
module seq_ctrl_vector_player #(
  parameter int VEC_DEPTH   = 32,
  parameter int CYC_PER_VEC = 8,
  parameter int ERR_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_ctrl_vector_player_if.slave bus
);
  localparam int VAW  = $clog2(VEC_DEPTH);
  localparam int EAW  = $clog2(VEC_DEPTH * CYC_PER_VEC);
  localparam int CAW  = (CYC_PER_VEC > 1) ? $clog2(CYC_PER_VEC) : 1;
  localparam int NEXP = VEC_DEPTH * CYC_PER_VEC;
  localparam logic [VAW:0]   NV_MAX   = (VAW+1)'(VEC_DEPTH);
  localparam logic [CAW-1:0] CYC_LAST = CAW'(CYC_PER_VEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [4:0]       stim_mem [VEC_DEPTH];
  logic [8:0]       exp_mem  [NEXP];
  logic [VAW-1:0]   vec_q;
  logic [CAW-1:0]   cyc_q;
  logic [EAW-1:0]   k_q, last_k_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, done_q, pass_q;
  logic [EAW-1:0]   first_idx_q;
  logic [8:0]       first_exp_q, first_got_q;
  logic [4:0]       stim_q;

  logic [VAW:0]     nv_clamp;
  logic [EAW-1:0]   last_k_d;
  logic [8:0]       exp_k;
  logic             mismatch;
  logic [4:0]       stim_next;

  always_comb begin
    nv_clamp  = (bus.num_vec > NV_MAX) ? NV_MAX : bus.num_vec;
    last_k_d  = EAW'(int'(nv_clamp) * CYC_PER_VEC - 1);
    exp_k     = exp_mem[k_q];
    mismatch  = (bus.dut_outs != exp_k);
    err_d     = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;
    stim_next = stim_mem[vec_q + 1'b1];
  end

  // Memory contents survive reset so an aborted run can be replayed without reloading.
  always_ff @(posedge clk) begin
    if (bus.stim_we && state_q != S_RUN) stim_mem[bus.stim_addr] <= bus.stim_data;
    if (bus.exp_we && state_q != S_RUN)  exp_mem[bus.exp_addr]   <= bus.exp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cyc_q       <= '0;
      k_q         <= '0;
      last_k_q    <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
      stim_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            err_q       <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
            vec_q       <= '0;
            cyc_q       <= '0;
            k_q         <= '0;
            last_k_q    <= last_k_d;
            if (nv_clamp != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
              stim_q  <= stim_mem[0];
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          k_q   <= k_q + 1'b1;
          err_q <= err_d;
          // err_q never returns to zero once counting, so this captures only the first miss.
          if (mismatch && err_q == '0) begin
            first_idx_q <= k_q;
            first_exp_q <= exp_k;
            first_got_q <= bus.dut_outs;
          end
          if (k_q == last_k_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else if (cyc_q == CYC_LAST) begin
            cyc_q  <= '0;
            vec_q  <= vec_q + 1'b1;
            stim_q <= stim_next;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_rst       = stim_q[4];
  assign bus.dut_zero      = stim_q[3];
  assign bus.dut_opcode    = stim_q[2:0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_idx_q;
  assign bus.first_err_exp = first_exp_q;
  assign bus.first_err_got = first_got_q;
endmodule

// File: tb/tb_seq_ctrl_vector_player.sv
// tb/tb_seq_ctrl_vector_player.sv - scoreboard bench for the vector player with a VeriRisc controller model
// Expected run results come from counting mismatches over the bench's own copy of the memories.
module tb_seq_ctrl_vector_player;
  localparam int VD  = 32;
  localparam int CPV = 8;
  localparam int NE  = VD * CPV;

  typedef struct {
    int busy;
    int pass;
    int err;
    int fidx;
    int fexp;
    int fgot;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [4:0] stim_m [VD];
  logic [8:0] exp_m  [NE];
  res_t       q16[$];
  res_t       q4[$];
  logic [2:0] ph16, ph4;
  int         bc16, bc4;
  logic       dprev16, dprev4;

  always #5 clk = ~clk;

  seq_ctrl_vector_player_if #(.VEC_DEPTH(VD), .CYC_PER_VEC(CPV), .ERR_W(16)) bus ();
  seq_ctrl_vector_player_if #(.VEC_DEPTH(VD), .CYC_PER_VEC(CPV), .ERR_W(4))  bus4 ();

  seq_ctrl_vector_player #(.VEC_DEPTH(VD), .CYC_PER_VEC(CPV), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  seq_ctrl_vector_player #(.VEC_DEPTH(VD), .CYC_PER_VEC(CPV), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));

  assign bus4.stim_we   = bus.stim_we;
  assign bus4.stim_addr = bus.stim_addr;
  assign bus4.stim_data = bus.stim_data;
  assign bus4.exp_we    = bus.exp_we;
  assign bus4.exp_addr  = bus.exp_addr;
  assign bus4.exp_data  = bus.exp_data;
  assign bus4.num_vec   = bus.num_vec;

  // VeriRisc sequence controller: 8-phase counter held at 0 while rst_n is low.
  function automatic logic [8:0] ctrl_dec(input logic [2:0] ph, input logic z, input logic [2:0] op);
    logic alu, hlt, skz, sto, jmp;
    logic rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    hlt = (op == 3'd0);
    skz = (op == 3'd1);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    {rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel} = 9'd0;
    case (ph)
      3'd0: sel = 1'b1;
      3'd1: begin sel = 1'b1; rd = 1'b1; end
      3'd2, 3'd3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
      3'd4: begin inc_pc = 1'b1; halt = hlt; end
      3'd5: rd = alu;
      3'd6: begin rd = alu; inc_pc = skz & z; ld_pc = jmp; data_e = sto; end
      default: begin rd = alu; ld_acc = alu; ld_pc = jmp; inc_pc = jmp; wr = sto; data_e = sto; end
    endcase
    return {rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel};
  endfunction

  always @(posedge clk or negedge bus.dut_rst)
    if (!bus.dut_rst) ph16 <= 3'd0; else ph16 <= ph16 + 3'd1;
  always @(posedge clk or negedge bus4.dut_rst)
    if (!bus4.dut_rst) ph4 <= 3'd0; else ph4 <= ph4 + 3'd1;
  assign bus.dut_outs  = ctrl_dec(ph16, bus.dut_zero, bus.dut_opcode);
  assign bus4.dut_outs = ctrl_dec(ph4, bus4.dut_zero, bus4.dut_opcode);

  // Every vector starts at phase 0: either held in reset or the counter has just wrapped.
  function automatic logic [8:0] golden(input int k);
    logic [4:0] s;
    s = stim_m[k / CPV];
    return ctrl_dec(s[4] ? 3'(k % CPV) : 3'd0, s[3], s[2:0]);
  endfunction

  function automatic res_t model(input int nv, input int errw);
    res_t r;
    int n, maxe;
    logic [8:0] g;
    n = (nv > VD) ? VD : nv;
    maxe = (1 << errw) - 1;
    r = '{default: 0};
    for (int k = 0; k < n * CPV; k++) begin
      g = golden(k);
      if (exp_m[k] !== g) begin
        if (r.err == 0) begin
          r.fidx = k;
          r.fexp = int'(exp_m[k]);
          r.fgot = int'(g);
        end
        if (r.err < maxe) r.err++;
      end
    end
    r.busy = n * CPV;
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) $display("FAIL %s: got %0h required %0h", nm, got, req);
    else n_pass++;
  endtask

  task automatic cmp_res(input string tag, input res_t e, input int bsy, input logic ps,
                         input logic [31:0] err, input logic [31:0] idx,
                         input logic [31:0] fe, input logic [31:0] fg);
    chk({tag, "_busy_cycles"}, 32'(bsy), 32'(e.busy));
    chk({tag, "_pass"}, 32'(ps), 32'(e.pass));
    chk({tag, "_err_count"}, err, 32'(e.err));
    chk({tag, "_first_idx"}, idx, 32'(e.fidx));
    chk({tag, "_first_exp"}, fe, 32'(e.fexp));
    chk({tag, "_first_got"}, fg, 32'(e.fgot));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bc16 = 0; dprev16 = 1'b0;
      bc4 = 0;  dprev4 = 1'b0;
    end else begin
      if (bus.busy) bc16++;
      if (bus4.busy) bc4++;
      if (bus.done && !dprev16) begin
        if (q16.size() == 0) chk("unexpected_done_p16", 32'(q16.size()), 32'd1);
        else cmp_res("p16", q16.pop_front(), bc16, bus.pass, 32'(bus.err_count),
                     32'(bus.first_err_idx), 32'(bus.first_err_exp), 32'(bus.first_err_got));
        bc16 = 0;
      end
      if (bus4.done && !dprev4) begin
        if (q4.size() == 0) chk("unexpected_done_p4", 32'(q4.size()), 32'd1);
        else cmp_res("p4", q4.pop_front(), bc4, bus4.pass, 32'(bus4.err_count),
                     32'(bus4.first_err_idx), 32'(bus4.first_err_exp), 32'(bus4.first_err_got));
        bc4 = 0;
      end
      dprev16 = bus.done;
      dprev4  = bus4.done;
    end
  end

  task automatic load_mem();
    for (int i = 0; i < NE; i++) begin
      @(negedge clk);
      bus.exp_we    = 1'b1;
      bus.exp_addr  = 8'(i);
      bus.exp_data  = exp_m[i];
      bus.stim_we   = (i < VD);
      bus.stim_addr = 5'(i % VD);
      bus.stim_data = stim_m[i % VD];
    end
    @(negedge clk);
    bus.exp_we  = 1'b0;
    bus.stim_we = 1'b0;
  endtask

  task automatic wr_exp(input int i);
    @(negedge clk);
    bus.exp_we = 1'b1; bus.exp_addr = 8'(i); bus.exp_data = exp_m[i];
    @(negedge clk);
    bus.exp_we = 1'b0;
  endtask

  task automatic start_run(input int nv, input bit on4, input bit push);
    @(negedge clk);
    bus.num_vec = 6'(nv);
    if (on4) bus4.start = 1'b1; else bus.start = 1'b1;
    if (push) begin
      if (on4) q4.push_back(model(nv, 4)); else q16.push_back(model(nv, 16));
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  task automatic wait_results();
    int t;
    t = 0;
    while ((q16.size() + q4.size()) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("result_timeout", 32'(q16.size() + q4.size()), 32'd0);
    q16.delete();
    q4.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dut_rst"}, 32'(bus.dut_rst), 32'd0);
    chk({tag, "_zero_op"}, 32'({bus.dut_zero, bus.dut_opcode}), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_count), 32'd0);
    chk({tag, "_first"}, 32'({bus.first_err_idx, bus.first_err_exp, bus.first_err_got}), 32'd0);
    chk({tag, "_p4_err_done"}, 32'({bus4.err_count, bus4.done, bus4.busy}), 32'd0);
  endtask

  task automatic set_test1();
    for (int i = 0; i < VD; i++) stim_m[i] = 5'd0;
    for (int i = 1; i < 8; i++) begin
      stim_m[i]     = {1'b1, 1'b0, 3'(i)};
      stim_m[i + 7] = {1'b1, 1'b1, 3'(i)};
    end
    stim_m[15] = {1'b1, 1'b0, 3'd0};
    for (int k = 0; k < NE; k++) exp_m[k] = golden(k);
  endtask

  initial begin
    bus.stim_we = 1'b0; bus.stim_addr = '0; bus.stim_data = '0;
    bus.exp_we = 1'b0;  bus.exp_addr = '0;  bus.exp_data = '0;
    bus.num_vec = '0; bus.start = 1'b0; bus4.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    set_test1();
    load_mem();
    start_run(16, 1'b0, 1'b1);
    wait_results();

    exp_m[37] = exp_m[37] ^ 9'h001;
    wr_exp(37);
    start_run(16, 1'b0, 1'b1);
    wait_results();
    exp_m[37] = exp_m[37] ^ 9'h001;
    wr_exp(37);

    start_run(16, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("midrun_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run(16, 1'b0, 1'b1);
    wait_results();

    start_run(16, 1'b0, 1'b1);
    repeat (19) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.num_vec = 6'd3;
    bus.stim_we = 1'b1; bus.stim_addr = 5'd3; bus.stim_data = ~stim_m[3];
    bus.exp_we = 1'b1;  bus.exp_addr = 8'd3;  bus.exp_data = ~exp_m[3];
    @(negedge clk);
    bus.start = 1'b0; bus.stim_we = 1'b0; bus.exp_we = 1'b0;
    wait_results();
    start_run(16, 1'b0, 1'b1);
    wait_results();

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run(0, 1'b0, 1'b1);
    chk("nv0_done_next_clock", 32'({bus.done, bus.pass, bus.busy}), 32'b110);
    wait_results();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < VD; i++) stim_m[i] = 5'($urandom);
      stim_m[0][4] = 1'b0;
      for (int k = 0; k < NE; k++) begin
        exp_m[k] = golden(k);
        if ($urandom_range(0, 99) < 2) exp_m[k] = exp_m[k] ^ 9'(1 << $urandom_range(0, 8));
      end
      load_mem();
      start_run(int'($urandom_range(1, 40)), 1'b0, 1'b1);
      wait_results();
    end

    set_test1();
    for (int k = 0; k < NE; k++) exp_m[k] = ~golden(k);
    load_mem();
    start_run(16, 1'b1, 1'b1);
    wait_results();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
